// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctrl
// Brief    : Flappy Bird frame sequencer: frame tick, game FSM, bird/pipe/score.
// Revision : 1.0
// ============================================================================
module game_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int START_Y    = 200,
    parameter int BIRD_H     = 16,
    parameter int GROUND_Y   = 440,
    parameter int PIPE_W     = 48,
    parameter int PIPE_SPEED = 2,
    parameter int GAP_MIN    = 100,
    parameter int FLAP_V     = 8,
    parameter int MAX_FALL   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x_crd,
    input  logic [9:0] y_crd,
    input  logic       btn_pressed,
    input  logic       collision,
    output logic [1:0] state,
    output logic       frame_tick,
    output logic [9:0] bird_y,
    output logic [9:0] pipe_x,
    output logic [9:0] gap_y,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [9:0]        C_START_Y   = 10'(START_Y);
    localparam logic [9:0]        C_GND_TOP   = 10'(GROUND_Y - BIRD_H);
    localparam logic [9:0]        C_PIPE_RST  = 10'(H_ACTIVE + PIPE_W);
    localparam logic [9:0]        C_PIPE_SPD  = 10'(PIPE_SPEED);
    localparam logic [9:0]        C_GAP_MIN   = 10'(GAP_MIN);
    localparam logic [9:0]        C_V_ACTIVE  = 10'(V_ACTIVE);
    localparam logic signed [7:0] C_VEL_FLAP  = 8'(-FLAP_V);
    localparam logic signed [7:0] C_MAX_FALL  = 8'(MAX_FALL);
    localparam logic [7:0]        C_LFSR_SEED = 8'hA5;

    state_t            state_q, state_d;
    logic              tick_q, hit_q;
    logic [9:0]        bird_q, bird_d;
    logic signed [7:0] vel_q, vel_d;
    logic [9:0]        pipe_q, pipe_d;
    logic [9:0]        gap_q, gap_d;
    logic [7:0]        score_q, score_d;
    logic [7:0]        lfsr_q;
    logic              coll_q, coll_d;
    logic              pend_q, pend_d;
    logic              btn_prev_q;
    logic              grnd_q, grnd_d;

    logic              w_hit;
    logic              w_press;
    logic              w_fb;
    logic signed [7:0] w_vel_grav;
    logic signed [7:0] w_vel_new;
    logic [10:0]       w_sum;
    logic [9:0]        w_mv_bird;
    logic signed [7:0] w_mv_vel;
    logic              w_mv_grnd;

    // Edge-detect the trigger coordinate so a pixel held for several clocks ticks once.
    assign w_hit   = (x_crd == 10'd0) && (y_crd == C_V_ACTIVE);
    assign w_press = btn_pressed & ~btn_prev_q;
    assign w_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    assign w_vel_grav = (vel_q >= C_MAX_FALL) ? C_MAX_FALL : vel_q + 8'sd1;
    assign w_vel_new  = ((state_q == S_IDLE) || ((state_q == S_PLAY) && pend_q))
                        ? C_VEL_FLAP : w_vel_grav;
    assign w_sum      = {1'b0, bird_q} + {{3{w_vel_new[7]}}, w_vel_new};

    always_comb begin
        w_mv_bird = w_sum[9:0];
        w_mv_vel  = w_vel_new;
        w_mv_grnd = 1'b0;
        if (w_sum[10]) begin
            w_mv_bird = 10'd0;
            w_mv_vel  = 8'sd0;
        end else if (w_sum[9:0] >= C_GND_TOP) begin
            w_mv_bird = C_GND_TOP;
            w_mv_grnd = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        bird_d  = bird_q;
        vel_d   = vel_q;
        pipe_d  = pipe_q;
        gap_d   = gap_q;
        score_d = score_q;
        grnd_d  = grnd_q;
        pend_d  = pend_q | w_press;
        coll_d  = coll_q | collision;
        if (tick_q) begin
            pend_d = w_press;
            coll_d = collision;
            case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        state_d = S_PLAY;
                        score_d = 8'd0;
                        bird_d  = w_mv_bird;
                        vel_d   = w_mv_vel;
                        grnd_d  = w_mv_grnd;
                    end
                end
                S_PLAY: begin
                    // Death freezes everything for this frame, including a pending wrap.
                    if (coll_q || grnd_q) begin
                        state_d = S_DYING;
                    end else begin
                        bird_d = w_mv_bird;
                        vel_d  = w_mv_vel;
                        grnd_d = w_mv_grnd;
                        if (pipe_q < C_PIPE_SPD) begin
                            pipe_d  = C_PIPE_RST;
                            gap_d   = C_GAP_MIN + {3'd0, lfsr_q[6:0]};
                            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        end else begin
                            pipe_d = pipe_q - C_PIPE_SPD;
                        end
                    end
                end
                S_DYING: begin
                    bird_d = w_mv_bird;
                    vel_d  = w_mv_vel;
                    grnd_d = w_mv_grnd;
                    if (w_mv_grnd) begin
                        state_d = S_OVER;
                    end
                end
                default: begin
                    if (pend_q) begin
                        state_d = S_IDLE;
                        bird_d  = C_START_Y;
                        vel_d   = 8'sd0;
                        pipe_d  = C_PIPE_RST;
                        grnd_d  = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_q     <= 1'b0;
            hit_q      <= 1'b0;
            bird_q     <= C_START_Y;
            vel_q      <= 8'sd0;
            pipe_q     <= C_PIPE_RST;
            gap_q      <= C_GAP_MIN;
            score_q    <= 8'd0;
            lfsr_q     <= C_LFSR_SEED;
            coll_q     <= 1'b0;
            pend_q     <= 1'b0;
            btn_prev_q <= 1'b0;
            grnd_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= w_hit & ~hit_q;
            hit_q      <= w_hit;
            bird_q     <= bird_d;
            vel_q      <= vel_d;
            pipe_q     <= pipe_d;
            gap_q      <= gap_d;
            score_q    <= score_d;
            lfsr_q     <= {lfsr_q[6:0], w_fb};
            coll_q     <= coll_d;
            pend_q     <= pend_d;
            btn_prev_q <= btn_pressed;
            grnd_q     <= grnd_d;
        end
    end

    assign state      = state_q;
    assign frame_tick = tick_q;
    assign bird_y     = bird_q;
    assign pipe_x     = pipe_q;
    assign gap_y      = gap_q;
    assign score      = score_q;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_ctrl
// Brief    : Self-checking bench for game_ctrl against a frame-level game model.
// Revision : 1.0
// ============================================================================
module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] x_crd;
    logic [9:0] y_crd;
    logic       btn_pressed;
    logic       collision;
    logic [1:0] state;
    logic       frame_tick;
    logic [9:0] bird_y;
    logic [9:0] pipe_x;
    logic [9:0] gap_y;
    logic [7:0] score;

    game_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x_crd       (x_crd),
        .y_crd       (y_crd),
        .btn_pressed (btn_pressed),
        .collision   (collision),
        .state       (state),
        .frame_tick  (frame_tick),
        .bird_y      (bird_y),
        .pipe_x      (pipe_x),
        .gap_y       (gap_y),
        .score       (score)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Game model: 0=IDLE 1=PLAY 2=DYING 3=OVER, plain integer arithmetic.
    int m_state, m_bird, m_vel, m_pipe, m_score;
    bit m_grnd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0; m_bird = 200; m_vel = 0; m_pipe = 688; m_score = 0; m_grnd = 0;
    endtask

    task automatic model_move();
        int s;
        s = m_bird + m_vel;
        if (s < 0) begin
            m_bird = 0; m_vel = 0; m_grnd = 0;
        end else if (s >= 424) begin
            m_bird = 424; m_grnd = 1;
        end else begin
            m_bird = s; m_grnd = 0;
        end
    endtask

    function automatic int gravity(input int v);
        return (v + 1 > 10) ? 10 : v + 1;
    endfunction

    task automatic model_frame(input bit pend, input bit coll);
        case (m_state)
            0: if (pend) begin
                m_state = 1; m_score = 0; m_vel = -8; model_move();
            end
            1: if (coll || m_grnd) begin
                m_state = 2;
            end else begin
                m_vel = pend ? -8 : gravity(m_vel);
                model_move();
                if (m_pipe < 2) begin
                    m_pipe = 688;
                    m_score = (m_score == 255) ? 255 : m_score + 1;
                end else begin
                    m_pipe = m_pipe - 2;
                end
            end
            2: begin
                m_vel = gravity(m_vel);
                model_move();
                if (m_grnd) m_state = 3;
            end
            default: if (pend) begin
                m_state = 0; m_bird = 200; m_vel = 0; m_pipe = 688; m_grnd = 0;
            end
        endcase
    endtask

    // One frame: random scan noise with optional double press / collision blip,
    // then the trigger coordinate held for two clocks.
    task automatic frame(input bit pend, input bit coll);
        for (int i = 0; i < 10; i++) begin
            x_crd       = 10'($urandom_range(1, 639));
            y_crd       = 10'($urandom_range(0, 479));
            btn_pressed = pend && (i == 2 || i == 5);
            collision   = coll && (i == 7);
            step();
            chk("tick_idle", {31'd0, frame_tick}, 0);
        end
        btn_pressed = 1'b0;
        collision   = 1'b0;
        x_crd = 10'd0;
        y_crd = 10'd480;
        step();
        chk("tick_pulse", {31'd0, frame_tick}, 1);
        step();
        chk("tick_width", {31'd0, frame_tick}, 0);
        model_frame(pend, coll);
        chk("state", {30'd0, state}, m_state);
        chk("bird_y", {22'd0, bird_y}, m_bird);
        chk("pipe_x", {22'd0, pipe_x}, m_pipe);
        chk("score", {24'd0, score}, m_score);
        chk("gap_range", {31'd0, (gap_y >= 10'd100) && (gap_y <= 10'd227)}, 1);
        x_crd = 10'd1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, {30'd0, state}, 0);
        chk({tag, "_tick"}, {31'd0, frame_tick}, 0);
        chk({tag, "_bird"}, {22'd0, bird_y}, 200);
        chk({tag, "_pipe"}, {22'd0, pipe_x}, 688);
        chk({tag, "_gap"}, {22'd0, gap_y}, 100);
        chk({tag, "_score"}, {24'd0, score}, 0);
    endtask

    function automatic bit rand_flap();
        return (m_bird > 250) || ($urandom_range(0, 3) == 0);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0; x_crd = 10'd5; y_crd = 10'd5; btn_pressed = 1'b0; collision = 1'b0;
        model_reset();
        repeat (3) step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        repeat (2) frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);
        repeat (6) frame(1'b0, 1'b0);

        n = 0;
        while (m_score < 1 && n < 400) begin
            frame(rand_flap(), 1'b0);
            n++;
        end
        chk("first_wrap", {24'd0, score}, 1);

        n = 0;
        while (m_pipe >= 2 && n < 400) begin
            frame(rand_flap(), 1'b0);
            n++;
        end
        frame(1'b1, 1'b1);
        chk("death_state", {30'd0, state}, 2);

        n = 0;
        while (m_state != 3 && n < 200) begin
            frame($urandom_range(0, 1) == 1, 1'b0);
            n++;
        end
        chk("reach_over", {30'd0, state}, 3);

        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        frame(1'b1, 1'b0);

        n = 0;
        while (m_state != 3 && n < 100) begin
            frame(1'b0, 1'b0);
            n++;
        end
        chk("ground_over", {30'd0, state}, 3);

        frame(1'b1, 1'b0);
        frame(1'b1, 1'b0);
        repeat (3) frame(1'b0, 1'b0);

        @(posedge clk);
        #7;
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("async_reset");
        step();
        rst_n = 1'b1;
        model_reset();
        step();
        repeat (2) frame(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Frame-level sequencer for the Flappy Bird game.
- Derives a once-per-frame update tick from the VGA scan coordinates and runs the game state machine (idle/play/dying/game over).
- Schedules bird physics, pipe scrolling, scoring and collision handling once per frame.
- Drives the object-position registers that the pixel renderer reads. It sits between the keyboard, the VGA timing and the renderer.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines; the frame tick fires at line V_ACTIVE
- START_Y, 200, bird top-edge y in IDLE
- BIRD_H, 16, bird height in pixels
- GROUND_Y, 440, first ground line; the bird is grounded when bird_y >= GROUND_Y-BIRD_H
- PIPE_W, 48, pipe width
- PIPE_SPEED, 2, pipe pixels moved per frame
- GAP_MIN, 100, minimum gap top
- FLAP_V, 8, upward velocity magnitude set by a flap
- MAX_FALL, 10, maximum downward velocity

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- x_crd  in  10  current scan x from VGA timing
- y_crd  in  10  current scan y from VGA timing
- btn_pressed  in  1  spacebar level from the keyboard; synchronous to clk
- collision  in  1  renderer flag: bird and pipe pixel lit at the same coordinate
- state  out  2  0=IDLE, 1=PLAY, 2=DYING, 3=OVER
- frame_tick  out  1  one-cycle pulse per frame
- bird_y  out  10  bird top edge
- pipe_x  out  10  pipe left edge; may exceed H_ACTIVE (offscreen)
- gap_y  out  10  top of the pipe gap
- score  out  8  pipes passed, saturating at 255

Behaviour:
- Reset values: state=IDLE, frame_tick=0, bird_y=START_Y, pipe_x=H_ACTIVE+PIPE_W, gap_y=GAP_MIN, score=0, velocity=0, LFSR=8'hA5, collision latch=0, btn_prev=0. Reset asserted mid-frame aborts all activity immediately.
- frame_tick: high for exactly one clk cycle when x_crd==0 and y_crd==V_ACTIVE, registered, so one cycle after the condition. All game-register updates occur only in the cycle frame_tick is high.
- Button: press = btn_pressed & ~btn_prev, sampled every cycle. A press is latched into a pending flag until the next frame_tick, where it is consumed. Multiple presses within one frame count as one flap.
- Collision: the latch sets on any cycle with collision=1 and clears at frame_tick after evaluation.
- LFSR: 8-bit, taps x^8+x^6+x^5+x^4+1, advances every clk cycle and never reaches 0.
- Velocity: 8-bit signed, positive = down. Each PLAY/DYING frame, velocity = min(velocity+1, MAX_FALL). In PLAY, a flap overrides this with velocity = -FLAP_V.
- bird_y update: sum = bird_y + sign-extended new velocity, computed at 11-bit signed width.
  - sum < 0: bird_y=0 and velocity=0 (ceiling, not fatal).
  - sum >= GROUND_Y-BIRD_H: bird_y = GROUND_Y-BIRD_H and the grounded flag is set.
- Pipe update (PLAY only): if pipe_x < PIPE_SPEED, then pipe_x = H_ACTIVE+PIPE_W, gap_y = GAP_MIN + LFSR[6:0], and score+1 (saturating). Otherwise pipe_x -= PIPE_SPEED.
- State transitions, evaluated at frame_tick:
  - IDLE: bird_y, pipe and velocity are held. A pending press gives PLAY, clears score, and applies the first flap in the same tick.
  - PLAY: a latched collision or grounded flag gives DYING. In that frame, bird and pipe do not move and score does not increment (death takes priority over flap and pipe wrap).
  - DYING: gravity only; flaps are ignored and the pipe is frozen. The grounded flag gives OVER.
  - OVER: everything frozen and score held. A pending press gives IDLE, which restores bird_y=START_Y, velocity=0 and pipe_x=H_ACTIVE+PIPE_W. Score is kept until the next PLAY entry.
- Presses arriving in DYING are discarded at tick (the pending flag is cleared).

Test Plan:
- Reset, run 2 frames with no input: frame_tick pulses once per frame, 1 clk wide, one cycle after (0,480); state=IDLE, bird_y=200, pipe_x=688, score=0.
- Press in IDLE, then no input: state=PLAY; velocity -8 then +1 per frame; bird_y follows 192,185,179,…; pipe_x decreases by 2 per frame.
- Continuous flaps every 4 frames until the pipe wraps: pipe_x<2 reloads to 688, score=1, gap_y is in 100..227, and the bird never goes below 0.
- Assert collision for 1 cycle mid-frame during PLAY on the frame the pipe would wrap: state=DYING at that tick, score unchanged, pipe frozen, flaps ignored, then OVER on reaching bird_y=424.
- In OVER, press: state=IDLE, bird_y=200, pipe_x=688, score retained; the next press clears score to 0.
- Deassert rst_n mid-PLAY, asynchronously off a clock edge: all outputs return to reset values immediately, without waiting for clk.
